mem_bus_unit: RTL and testbench

Parametrised external-memory bus interface that replaces ad-hoc pad buffering and fixed PC/decoder address muxing with a sequenced, arbitrated bus master. It takes N_CH internal requesters (channel 0 = program counter fetch, channel 1 = decoder/ALU data, further channels for future units). It grants one requester at a time with round-robin fairness, then runs a read or write cycle with programmable wait states and external ready. It also supports multi-transaction bus locking and honours an external lock line. It sits between the core units and the top-level pad buffers.

---
 rtl/mem_bus_pkg.sv | 13 +
 rtl/mem_bus_unit_arbiter.sv | 32 +++
 rtl/mem_bus_unit.sv | 159 +++++++++++++++
 tb/tb_mem_bus_unit.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types for the external-memory bus master: FSM states and bus direction codes.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/mem_bus_unit_arbiter.sv
// Round-robin picker: first requesting, unmasked channel at or after the pointer, wrapping modulo N_CH.
module rr_arbiter #(
  parameter int N_CH  = 2,
  parameter int PTR_W = 1
) (
  input  logic [N_CH-1:0]  i_req,
  input  logic [PTR_W-1:0] i_ptr,
  input  logic [N_CH-1:0]  i_mask,
  output logic [N_CH-1:0]  o_pick,
  output logic             o_valid
);

  always_comb begin
    logic [PTR_W:0]   w_sum;
    logic [PTR_W-1:0] w_idx;
    o_pick  = '0;
    o_valid = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int i = 0; i < N_CH; i++) begin
      // Pointer and offset are both below N_CH, so one subtraction wraps the sum.
      w_sum = {1'b0, i_ptr} + (PTR_W+1)'(i);
      if (w_sum >= (PTR_W+1)'(N_CH)) w_sum = w_sum - (PTR_W+1)'(N_CH);
      w_idx = w_sum[PTR_W-1:0];
      if (!o_valid && i_req[w_idx] && i_mask[w_idx]) begin
        o_pick[w_idx] = 1'b1;
        o_valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_bus_unit.sv
// Arbitrated external-memory bus master: round-robin grant, wait-state/ready sequenced access,
// and multi-transaction bus locking that honours a shared external lock line.
module mem_bus_unit
  import mem_bus_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int N_CH   = 2,
  parameter int WAIT_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          i_req,
  input  logic [N_CH-1:0]          i_we,
  input  logic [N_CH*ADDR_W-1:0]   i_addr,
  input  logic [N_CH*DATA_W-1:0]   i_wdata,
  input  logic [N_CH-1:0]          i_lock_req,
  output logic [N_CH-1:0]          o_gnt,
  output logic [N_CH-1:0]          o_done,
  output logic [DATA_W-1:0]        o_rdata,
  output logic                     o_busy,
  input  logic [WAIT_W-1:0]        i_wait_cycles,
  input  logic                     i_ready,
  output logic [ADDR_W-1:0]        o_addr,
  output logic [DATA_W-1:0]        o_wdata,
  output logic                     o_rw,
  output logic                     o_data_oe,
  input  logic [DATA_W-1:0]        i_rdata,
  output logic                     o_lock,
  input  logic                     i_lock
);

  localparam int PTR_W = $clog2(N_CH);

  state_t              r_state;
  logic [PTR_W-1:0]    r_ptr;
  logic [PTR_W-1:0]    r_g;
  logic [PTR_W-1:0]    r_own;
  logic                r_own_vld;
  logic                r_lk;
  logic                r_we;
  logic                r_oe;
  logic [WAIT_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic [N_CH-1:0]     r_gnt;
  logic [N_CH-1:0]     r_done;

  logic                w_own_keep;
  logic [N_CH-1:0]     w_mask;
  logic [N_CH-1:0]     w_pick;
  logic                w_pick_vld;
  logic [PTR_W-1:0]    w_pick_idx;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(N_CH-1)) ? '0 : p + 1'b1;
  endfunction

  // An owner whose lock request dropped is released this cycle and no longer restricts the grant.
  assign w_own_keep = r_own_vld & i_lock_req[r_own];

  always_comb begin
    if (w_own_keep)  w_mask = {{(N_CH-1){1'b0}}, 1'b1} << r_own;
    else if (i_lock) w_mask = '0;
    else             w_mask = '1;
  end

  rr_arbiter #(
    .N_CH  (N_CH),
    .PTR_W (PTR_W)
  ) u_arb (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .i_mask  (w_mask),
    .o_pick  (w_pick),
    .o_valid (w_pick_vld)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_pick[i]) w_pick_idx = PTR_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_g       <= '0;
      r_own     <= '0;
      r_own_vld <= 1'b0;
      r_lk      <= 1'b0;
      r_we      <= RW_READ;
      r_oe      <= 1'b0;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_gnt     <= '0;
      r_done    <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        IDLE: begin
          if (r_own_vld && !i_lock_req[r_own]) r_own_vld <= 1'b0;
          if (w_pick_vld) begin
            r_state <= ACCESS;
            r_gnt   <= w_pick;
            r_g     <= w_pick_idx;
            r_we    <= i_we[w_pick_idx];
            r_oe    <= (i_we[w_pick_idx] == RW_WRITE);
            r_addr  <= i_addr[w_pick_idx*ADDR_W +: ADDR_W];
            r_wdata <= i_wdata[w_pick_idx*DATA_W +: DATA_W];
            r_cnt   <= i_wait_cycles;
            r_lk    <= i_lock_req[w_pick_idx];
          end
        end
        ACCESS: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (i_ready) begin
            r_state <= DONE;
            r_done  <= r_gnt;
            r_oe    <= 1'b0;
            if (r_we == RW_READ) r_rdata <= i_rdata;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_we    <= RW_READ;
          r_addr  <= '0;
          r_wdata <= '0;
          r_lk    <= 1'b0;
          r_ptr   <= next_ptr(r_g);
          if (i_lock_req[r_g]) begin
            r_own_vld <= 1'b1;
            r_own     <= r_g;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_gnt     = r_gnt;
  assign o_done    = r_done;
  assign o_rdata   = r_rdata;
  assign o_busy    = (r_state != IDLE);
  assign o_addr    = r_addr;
  assign o_wdata   = r_wdata;
  assign o_rw      = r_we;
  assign o_data_oe = r_oe;
  // r_lk is only set between grant and the end of DONE.
  assign o_lock    = r_own_vld | r_lk;

endmodule

// File: tb/tb_mem_bus_unit.sv
// Bench for mem_bus_unit: directed scenarios plus randomized traffic, checked by a transaction-level
// model of arbitration/locking and a completion scoreboard.
`timescale 1ns/1ps
module tb_mem_bus_unit;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int N_CH   = 3;
  localparam int WAIT_W = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_CH-1:0]        i_req, i_we, i_lock_req;
  logic [N_CH*ADDR_W-1:0] i_addr;
  logic [N_CH*DATA_W-1:0] i_wdata;
  logic [N_CH-1:0]        o_gnt, o_done;
  logic [DATA_W-1:0]      o_rdata, o_wdata, i_rdata;
  logic                   o_busy, o_rw, o_data_oe, o_lock, i_lock, i_ready;
  logic [WAIT_W-1:0]      i_wait_cycles;
  logic [ADDR_W-1:0]      o_addr;

  logic [DATA_W-1:0] mem_tbl [64];
  assign i_rdata = mem_tbl[o_addr[5:0]];

  mem_bus_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_CH(N_CH), .WAIT_W(WAIT_W)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_lock_req(i_lock_req), .o_gnt(o_gnt), .o_done(o_done), .o_rdata(o_rdata), .o_busy(o_busy),
    .i_wait_cycles(i_wait_cycles), .i_ready(i_ready), .o_addr(o_addr), .o_wdata(o_wdata),
    .o_rw(o_rw), .o_data_oe(o_data_oe), .i_rdata(i_rdata), .o_lock(o_lock), .i_lock(i_lock)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Input values as seen by the DUT at each rising edge.
  logic [N_CH-1:0]        e_req, e_we, e_lockreq;
  logic [N_CH*ADDR_W-1:0] e_addr;
  logic [N_CH*DATA_W-1:0] e_wdata;
  logic                   e_lock, e_ready;
  logic [WAIT_W-1:0]      e_wait;
  always @(posedge clk) begin
    e_req = i_req; e_we = i_we; e_lockreq = i_lock_req; e_addr = i_addr; e_wdata = i_wdata;
    e_lock = i_lock; e_ready = i_ready; e_wait = i_wait_cycles;
  end

  typedef struct packed {
    int                ch;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } txn_t;
  txn_t sb_q[$];

  typedef enum {PH_IDLE, PH_ACC, PH_DONE} ph_t;
  ph_t               m_ph = PH_IDLE;
  int                m_ptr = 0, m_g = 0, m_own = 0, m_j = 0, m_w = 0, m_c;
  bit                m_own_vld = 0, m_lk = 0, m_we = 0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_wdata = '0;
  logic [N_CH-1:0]   m_elig;
  txn_t              m_t;

  function automatic int rr_pick(input logic [N_CH-1:0] elig, input int ptr);
    int c;
    for (int k = 0; k < N_CH; k++) begin
      c = (ptr + k) % N_CH;
      if (elig[c]) return c;
    end
    return -1;
  endfunction

  // Transaction-level model: each falling edge accounts for the rising edge just passed.
  always @(negedge clk) begin
    if (rst) begin
      m_ph = PH_IDLE; m_ptr = 0; m_own_vld = 0; m_lk = 0;
      sb_q.delete();
    end else begin
      case (m_ph)
        PH_DONE: begin
          m_ptr = (m_g + 1) % N_CH;
          if (e_lockreq[m_g]) begin m_own_vld = 1; m_own = m_g; end
          m_ph = PH_IDLE;
        end
        PH_ACC: begin
          if (m_j >= m_w && e_ready) m_ph = PH_DONE;
          else m_j++;
        end
        default: begin
          if (m_own_vld && !e_lockreq[m_own]) m_own_vld = 0;
          if (m_own_vld)   m_elig = '0 | (N_CH'(1) << m_own);
          else if (e_lock) m_elig = '0;
          else             m_elig = '1;
          m_c = rr_pick(e_req & m_elig, m_ptr);
          if (m_c >= 0) begin
            m_g = m_c; m_we = e_we[m_c]; m_lk = e_lockreq[m_c];
            m_addr = e_addr[m_c*ADDR_W +: ADDR_W]; m_wdata = e_wdata[m_c*DATA_W +: DATA_W];
            m_w = int'(e_wait); m_j = 0; m_ph = PH_ACC;
            m_t.ch = m_c; m_t.we = m_we; m_t.addr = m_addr; m_t.wdata = m_wdata;
            sb_q.push_back(m_t);
          end
        end
      endcase
      chk("gnt",  o_gnt,  (m_ph == PH_IDLE) ? 0 : (1 << m_g));
      chk("done", o_done, (m_ph == PH_DONE) ? (1 << m_g) : 0);
      chk("busy", o_busy, m_ph != PH_IDLE);
      chk("lock", o_lock, m_own_vld || (m_ph != PH_IDLE && m_lk));
      if (m_ph == PH_ACC) begin
        chk("addr",  o_addr,    m_addr);
        chk("rw",    o_rw,      m_we);
        chk("wdata", o_wdata,   m_wdata);
        chk("oe",    o_data_oe, m_we);
      end else if (m_ph == PH_IDLE) begin
        chk("idle_addr", o_addr, 0);
        chk("idle_oe",   o_data_oe, 0);
        chk("idle_rw",   o_rw, 0);
      end
    end
  end

  // Completion scoreboard.
  logic [DATA_W-1:0] sb_last = '0;
  txn_t              sb_t;
  always @(negedge clk) begin
    if (rst) begin
      sb_last = '0;
    end else if (o_done != '0) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_done", o_done, 0);
      end else begin
        sb_t = sb_q.pop_front();
        chk("sb_done_ch", o_done, 1 << sb_t.ch);
        if (!sb_t.we) sb_last = mem_tbl[sb_t.addr[5:0]];
        chk("sb_rdata", o_rdata, sb_last);
      end
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic issue(input int ch, input logic we, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    i_req[ch] = 1'b1; i_we[ch] = we;
    i_addr[ch*ADDR_W +: ADDR_W] = a; i_wdata[ch*DATA_W +: DATA_W] = d;
  endtask

  task automatic wait_done(input int ch, output int cyc);
    cyc = 0;
    do begin step(); cyc++; end while (!o_done[ch] && cyc < 60);
    chk("done_seen", o_done[ch], 1);
  endtask

  int cyc, acc, nseq;
  int seq [8];

  initial begin
    rst = 1; i_req = '0; i_we = '0; i_lock_req = '0; i_addr = '0; i_wdata = '0;
    i_lock = 0; i_ready = 1; i_wait_cycles = '0;
    for (int k = 0; k < 64; k++) mem_tbl[k] = DATA_W'($urandom);
    mem_tbl[6'h34] = 16'hBEEF;
    repeat (3) step();
    chk("rst_gnt", o_gnt, 0);   chk("rst_done", o_done, 0); chk("rst_busy", o_busy, 0);
    chk("rst_lock", o_lock, 0); chk("rst_rdata", o_rdata, 0); chk("rst_oe", o_data_oe, 0);
    rst = 0;

    // Single zero-wait read.
    issue(0, 1'b0, 16'h1234, 16'h0);
    wait_done(0, cyc);
    chk("rd_latency", cyc, 2);
    chk("rd_data", o_rdata, 16'hBEEF);
    i_req[0] = 0;
    step();

    // Write with 3 wait states and 2 ready-low cycles.
    i_wait_cycles = 4'd3; i_ready = 0; acc = 0; cyc = 0;
    issue(1, 1'b1, 16'h8000, 16'h00A5);
    do begin
      step(); cyc++;
      if (o_gnt[1] && !o_done[1]) begin
        acc++;
        chk("wr_oe", o_data_oe, 1);
        chk("wr_wdata", o_wdata, 16'h00A5);
        if (acc == 6) i_ready = 1;
      end
    end while (!o_done[1] && cyc < 60);
    chk("wr_access_cycles", acc, 6);
    chk("wr_done_cycle", cyc, 7);
    chk("wr_rdata_kept", o_rdata, 16'hBEEF);
    i_req[1] = 0; i_ready = 1; i_wait_cycles = '0;
    step();

    // Round-robin from reset with two continuous requesters.
    rst = 1; step(); rst = 0;
    issue(0, 1'b0, 16'h0011, 16'h0); issue(1, 1'b0, 16'h0022, 16'h0);
    nseq = 0; cyc = 0;
    while (nseq < 8 && cyc < 200) begin
      step(); cyc++;
      for (int c = 0; c < N_CH; c++) if (o_done[c]) begin seq[nseq] = c; nseq++; end
    end
    chk("rr_count", nseq, 8);
    for (int k = 0; k < 8; k++) chk("rr_order", seq[k], k % 2);
    i_req = '0;
    step();

    // Lock hold: ch1 keeps the bus for 3 accesses while ch0 waits.
    i_lock_req[1] = 1;
    issue(1, 1'b0, 16'h0005, 16'h0);
    nseq = 0; cyc = 0;
    while (nseq < 4 && cyc < 200) begin
      step(); cyc++;
      for (int c = 0; c < N_CH; c++) if (o_done[c]) begin seq[nseq] = c; nseq++; end
      if (o_done[1]) chk("lk_lock_line", o_lock, 1);
      if (nseq == 1 && o_done[1]) issue(0, 1'b1, 16'h0007, 16'h1357);
      if (nseq == 3 && o_done[1]) begin i_req[1] = 0; i_lock_req[1] = 0; end
      if (o_done[0]) i_req[0] = 0;
    end
    chk("lk_count", nseq, 4);
    chk("lk_seq0", seq[0], 1); chk("lk_seq1", seq[1], 1);
    chk("lk_seq2", seq[2], 1); chk("lk_seq3", seq[3], 0);
    i_req = '0;
    repeat (2) step();

    // External lock blocks grants; a lock rising mid-access does not disturb it.
    i_lock = 1;
    issue(0, 1'b0, 16'h0034, 16'h0);
    repeat (4) begin step(); chk("xl_nogrant", o_gnt, 0); end
    i_lock = 0;
    step();
    chk("xl_grant_after_release", o_gnt, 3'b001);
    wait_done(0, cyc);
    i_req[0] = 0; i_wait_cycles = 4'd4;
    step();
    issue(0, 1'b1, 16'h0044, 16'h0BAD);
    step();
    chk("xl_in_access", o_gnt, 3'b001);
    i_lock = 1;
    wait_done(0, cyc);
    i_lock = 0; i_req[0] = 0; i_wait_cycles = '0;
    step();

    // Asynchronous reset in the middle of a pending write.
    i_wait_cycles = 4'd5;
    issue(0, 1'b1, 16'h4444, 16'h5555);
    repeat (3) step();
    chk("ar_pre_oe", o_data_oe, 1);
    #1 rst = 1;
    #1;
    chk("ar_gnt", o_gnt, 0); chk("ar_done", o_done, 0); chk("ar_oe", o_data_oe, 0);
    chk("ar_busy", o_busy, 0); chk("ar_addr", o_addr, 0); chk("ar_wdata", o_wdata, 0);
    chk("ar_rw", o_rw, 0); chk("ar_rdata", o_rdata, 0); chk("ar_lock", o_lock, 0);
    i_req = '0; i_wait_cycles = '0;
    step(); step();
    rst = 0;
    repeat (2) begin step(); chk("ar_after_busy", o_busy, 0); chk("ar_after_done", o_done, 0); end

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      step();
      if (n == 2000) begin rst = 1; step(); rst = 0; end
      for (int c = 0; c < N_CH; c++) begin
        if (o_done[c]) begin
          if ($urandom_range(0, 1) == 1) issue(c, 1'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
          else i_req[c] = 0;
        end else if (!i_req[c] && $urandom_range(0, 3) == 0) begin
          issue(c, 1'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
        end
        if ($urandom_range(0, 7) == 0) i_lock_req[c] = ~i_lock_req[c];
      end
      i_lock        = ($urandom_range(0, 11) == 0);
      i_ready       = ($urandom_range(0, 3) != 0);
      i_wait_cycles = WAIT_W'($urandom_range(0, 5));
    end
    i_req = '0; i_lock_req = '0; i_lock = 0; i_ready = 1;
    repeat (20) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
